atm_keypad_entry: RTL and testbench

ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

---
 rtl/atm_pkg.sv | 30 +++
 rtl/atm_digit_shift.sv | 29 ++
 rtl/atm_keypad_entry.sv | 165 ++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad entry block: FSM states, op codes
// and field geometry.
package atm_pkg;

  localparam int FIELD_W    = 12;
  localparam int NUM_FIELDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_PINE  = 3'd2,
    ST_OPSEL = 3'd3,
    ST_DST   = 3'd4,
    ST_AMT   = 3'd5,
    ST_SEND  = 3'd6
  } entry_state_t;

  localparam logic [2:0] OP_DEPOSIT  = 3'd0;
  localparam logic [2:0] OP_WITHDRAW = 3'd1;
  localparam logic [2:0] OP_TRANSFER = 3'd2;
  localparam logic [2:0] OP_BALANCE  = 3'd3;
  localparam logic [2:0] OP_EXIT     = 3'd4;

  // Index of each digit field within the per-field shifter array
  localparam logic [1:0] FLD_ACC = 2'd0;
  localparam logic [1:0] FLD_PIN = 2'd1;
  localparam logic [1:0] FLD_DST = 2'd2;
  localparam logic [1:0] FLD_AMT = 2'd3;

endpackage

// File: rtl/atm_digit_shift.sv
// Three-digit hex entry field: shifts digits in from the right, saturates at
// three digits, and clears on request.
module atm_digit_shift
  import atm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic [3:0]         digit,
  output logic [FIELD_W-1:0] value,
  output logic [1:0]         count
);

  // Clear wins over a digit; once full, further digits are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (shift_en && count != 2'd3) begin
      value <= {value[FIELD_W-5:0], digit};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad session controller: assembles account, PIN, op code, destination and
// amount from key strobes and offers the request to the ATM core.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_digit,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               key_cancel,
  input  logic               req_ready,
  output logic [FIELD_W-1:0] Account_Number,
  output logic [FIELD_W-1:0] PIN,
  output logic [FIELD_W-1:0] Destination_Account,
  output logic [FIELD_W-1:0] Amount,
  output logic [2:0]         Operation,
  output logic               req_valid,
  output logic               timeout,
  output logic [2:0]         entry_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  entry_state_t state, next_state;

  logic [FIELD_W-1:0]    field_val [NUM_FIELDS];
  logic [1:0]            field_cnt [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] shift_en;
  logic [NUM_FIELDS-1:0] field_clr;
  logic                  op_load, op_clr, op_seen;
  logic [CW-1:0]         idle_cnt;
  logic                  any_strobe, counting, handshake, timeout_fire;
  logic [1:0]            cur_field;
  logic                  has_field;

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    atm_digit_shift u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en[g]),
      .clear    (field_clr[g]),
      .digit    (key_digit),
      .value    (field_val[g]),
      .count    (field_cnt[g])
    );
  end

  assign Account_Number      = field_val[FLD_ACC];
  assign PIN                 = field_val[FLD_PIN];
  assign Destination_Account = field_val[FLD_DST];
  assign Amount              = field_val[FLD_AMT];
  assign entry_state         = state;

  assign any_strobe   = key_valid | key_enter | key_clear | key_cancel;
  assign counting     = (state != ST_IDLE) && (state != ST_SEND);
  assign handshake    = (state == ST_SEND) && req_valid && req_ready;
  assign timeout_fire = counting && !any_strobe && (idle_cnt == IDLE_LIMIT);

  always_comb begin
    has_field = 1'b1;
    cur_field = FLD_ACC;
    case (state)
      ST_ACC:  cur_field = FLD_ACC;
      ST_PINE: cur_field = FLD_PIN;
      ST_DST:  cur_field = FLD_DST;
      ST_AMT:  cur_field = FLD_AMT;
      default: has_field = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Only the highest-priority strobe acts: cancel > clear > enter > digit
  always_comb begin
    next_state = state;
    shift_en   = '0;
    field_clr  = '0;
    op_load    = 1'b0;
    op_clr     = 1'b0;
    if (timeout_fire) begin
      next_state = ST_IDLE;
      field_clr  = '1;
      op_clr     = 1'b1;
    end else if (state == ST_SEND) begin
      if (handshake) begin
        op_clr = 1'b1;
        if (Operation == OP_EXIT) begin
          next_state = ST_IDLE;
          field_clr  = '1;
        end else begin
          next_state         = ST_OPSEL;
          field_clr[FLD_DST] = 1'b1;
          field_clr[FLD_AMT] = 1'b1;
        end
      end
    end else if (key_cancel) begin
      next_state = ST_IDLE;
      field_clr  = '1;
      op_clr     = 1'b1;
    end else if (key_clear) begin
      if (state == ST_OPSEL) op_clr = 1'b1;
      else if (has_field)    field_clr[cur_field] = 1'b1;
    end else if (key_enter) begin
      case (state)
        ST_ACC:  if (field_cnt[FLD_ACC] == 2'd3) next_state = ST_PINE;
        ST_PINE: if (field_cnt[FLD_PIN] == 2'd3) next_state = ST_OPSEL;
        ST_DST:  if (field_cnt[FLD_DST] == 2'd3) next_state = ST_AMT;
        ST_AMT:  if (field_cnt[FLD_AMT] != 2'd0) next_state = ST_SEND;
        ST_OPSEL: begin
          if (op_seen) begin
            if (Operation == OP_DEPOSIT || Operation == OP_WITHDRAW) next_state = ST_AMT;
            else if (Operation == OP_TRANSFER)                      next_state = ST_DST;
            else                                                     next_state = ST_SEND;
          end
        end
        default: ;
      endcase
    end else if (key_valid) begin
      if (state == ST_IDLE) begin
        shift_en[FLD_ACC] = 1'b1;
        next_state        = ST_ACC;
      end else if (state == ST_OPSEL) begin
        op_load = !key_digit[3];
      end else if (has_field) begin
        shift_en[cur_field] = 1'b1;
      end
    end
  end

  // op_seen gates the OPSEL enter so it only acts after a valid op digit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Operation <= OP_DEPOSIT;
      op_seen   <= 1'b0;
    end else if (op_clr) begin
      Operation <= OP_DEPOSIT;
      op_seen   <= 1'b0;
    end else if (op_load) begin
      Operation <= key_digit[2:0];
      op_seen   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid <= 1'b0;
      timeout   <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      req_valid <= (next_state == ST_SEND);
      timeout   <= timeout_fire;
      if (any_strobe || handshake || !counting || timeout_fire) idle_cnt <= '0;
      else                                                       idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: a digit-list session model predicts
// each offered request and each inactivity abort.
module tb_atm_keypad_entry;

  localparam int T = 8;
  localparam int S_IDLE = 0, S_ACC = 1, S_PINE = 2, S_OPSEL = 3, S_DST = 4, S_AMT = 5, S_SEND = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0, key_cancel = 1'b0;
  logic        req_ready = 1'b0;
  logic [3:0]  key_digit = 4'h0;
  logic [11:0] Account_Number, PIN, Destination_Account, Amount;
  logic [2:0]  Operation, entry_state;
  logic        req_valid, timeout;

  int checks = 0;
  int errors = 0;
  bit rr_hold = 1'b0;

  typedef struct {
    int acc;
    int pin;
    int dst;
    int amt;
    int op;
  } req_t;

  req_t exp_q[$];
  int   dq[4][$];
  int   m_state = S_IDLE;
  int   m_op = 0;
  int   m_idle = 0;
  int   to_pending = 0;
  bit   m_seen = 1'b0;

  atm_keypad_entry #(.TIMEOUT_CYCLES(T)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .key_valid           (key_valid),
    .key_digit           (key_digit),
    .key_enter           (key_enter),
    .key_clear           (key_clear),
    .key_cancel          (key_cancel),
    .req_ready           (req_ready),
    .Account_Number      (Account_Number),
    .PIN                 (PIN),
    .Destination_Account (Destination_Account),
    .Amount              (Amount),
    .Operation           (Operation),
    .req_valid           (req_valid),
    .timeout             (timeout),
    .entry_state         (entry_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  // Fields are kept as lists of entered digits; the value is their hex reading
  function automatic int fval(int i);
    int v = 0;
    for (int k = 0; k < dq[i].size(); k++) v = v * 16 + dq[i][k];
    return v;
  endfunction

  function automatic void zero_all();
    for (int i = 0; i < 4; i++) dq[i].delete();
    m_op   = 0;
    m_seen = 1'b0;
  endfunction

  function automatic int field_of(int s);
    case (s)
      S_ACC:   return 0;
      S_PINE:  return 1;
      S_DST:   return 2;
      S_AMT:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    zero_all();
    m_state    = S_IDLE;
    m_idle     = 0;
    to_pending = 0;
    exp_q.delete();
  endfunction

  // Predicts the session after the coming clock edge from the driven inputs
  function automatic void model_step();
    bit   strobe   = key_valid || key_enter || key_clear || key_cancel;
    bit   counting = (m_state != S_IDLE) && (m_state != S_SEND);
    int   f        = field_of(m_state);
    int   prev     = m_state;
    req_t r;
    if (counting && !strobe && m_idle == T - 1) begin
      zero_all();
      m_state = S_IDLE;
      m_idle  = 0;
      to_pending++;
      return;
    end
    m_idle = (strobe || !counting) ? 0 : m_idle + 1;
    if (m_state == S_SEND) begin
      if (req_ready) begin
        if (m_op == 4) begin
          zero_all();
          m_state = S_IDLE;
        end else begin
          dq[2].delete();
          dq[3].delete();
          m_op    = 0;
          m_seen  = 1'b0;
          m_state = S_OPSEL;
        end
      end
      return;
    end
    if (key_cancel) begin
      zero_all();
      m_state = S_IDLE;
    end else if (key_clear) begin
      if (m_state == S_OPSEL) begin
        m_op   = 0;
        m_seen = 1'b0;
      end else if (f >= 0) begin
        dq[f].delete();
      end
    end else if (key_enter) begin
      case (m_state)
        S_ACC:   if (dq[0].size() == 3) m_state = S_PINE;
        S_PINE:  if (dq[1].size() == 3) m_state = S_OPSEL;
        S_DST:   if (dq[2].size() == 3) m_state = S_AMT;
        S_AMT:   if (dq[3].size() >= 1) m_state = S_SEND;
        S_OPSEL: if (m_seen) m_state = (m_op <= 1) ? S_AMT : (m_op == 2) ? S_DST : S_SEND;
        default: ;
      endcase
    end else if (key_valid) begin
      if (m_state == S_IDLE) begin
        dq[0].push_back(int'(key_digit));
        m_state = S_ACC;
      end else if (m_state == S_OPSEL) begin
        if (key_digit < 4'd8) begin
          m_op   = int'(key_digit);
          m_seen = 1'b1;
        end
      end else if (f >= 0 && dq[f].size() < 3) begin
        dq[f].push_back(int'(key_digit));
      end
    end
    if (m_state == S_SEND && prev != S_SEND) begin
      r.acc = fval(0);
      r.pin = fval(1);
      r.dst = fval(2);
      r.amt = fval(3);
      r.op  = m_op;
      exp_q.push_back(r);
    end
  endfunction

  task automatic applyStimulus(input bit kv, input logic [3:0] kd, input bit ke,
                               input bit kc, input bit kx, input bit rr);
    key_valid  = kv;
    key_digit  = kd;
    key_enter  = ke;
    key_clear  = kc;
    key_cancel = kx;
    req_ready  = rr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, rr_hold);
  endtask

  task automatic press_enter();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, rr_hold);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, rr_hold);
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_state"}, entry_state, m_state);
    checkOutput({tag, "_acc"}, Account_Number, fval(0));
    checkOutput({tag, "_pin"}, PIN, fval(1));
    checkOutput({tag, "_dst"}, Destination_Account, fval(2));
    checkOutput({tag, "_amt"}, Amount, fval(3));
    checkOutput({tag, "_op"}, Operation, m_op);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_acc"}, Account_Number, 0);
    checkOutput({tag, "_pin"}, PIN, 0);
    checkOutput({tag, "_dst"}, Destination_Account, 0);
    checkOutput({tag, "_amt"}, Amount, 0);
    checkOutput({tag, "_op"}, Operation, 0);
    checkOutput({tag, "_state"}, entry_state, S_IDLE);
  endtask

  // Monitor: compares every offered request against the head of the queue
  always @(negedge clk) begin
    if (rst) begin
      if (req_valid) begin
        checkOutput("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          checkOutput("req_acc", Account_Number, exp_q[0].acc);
          checkOutput("req_pin", PIN, exp_q[0].pin);
          checkOutput("req_dst", Destination_Account, exp_q[0].dst);
          checkOutput("req_amt", Amount, exp_q[0].amt);
          checkOutput("req_op", Operation, exp_q[0].op);
          if (req_ready) void'(exp_q.pop_front());
        end
      end
      if (timeout) begin
        checkOutput("timeout_expected", to_pending > 0, 1);
        if (to_pending > 0) to_pending--;
        checkOutput("timeout_state", entry_state, S_IDLE);
        checkOutput("timeout_acc", Account_Number, 0);
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check_all_zero("reset");
    checkOutput("reset_valid", req_valid, 0);
    checkOutput("reset_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Non-digit strobes leave the idle outputs alone
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_all_zero("idle_hold");

    // Deposit path, ready already high
    rr_hold = 1'b1;
    repeat (3) press_key(4'hF);
    press_enter();
    checkOutput("acc_to_pine", entry_state, S_PINE);
    repeat (3) press_key(4'hF);
    press_enter();
    checkOutput("pine_to_opsel", entry_state, S_OPSEL);
    press_key(4'h0);
    press_enter();
    checkOutput("op0_to_amt", entry_state, S_AMT);
    press_key(4'h1);
    press_key(4'h1);
    press_key(4'hF);
    press_enter();
    checkOutput("send_latency", req_valid, 1);
    checkOutput("send_amt", Amount, 12'h11F);
    checkOutput("send_acc", Account_Number, 12'hFFF);
    idle_cycles(1);
    checkOutput("hs_state", entry_state, S_OPSEL);
    checkOutput("hs_valid", req_valid, 0);
    checkOutput("hs_pin_kept", PIN, 12'hFFF);
    checkOutput("hs_amt_zero", Amount, 0);

    // Transfer path with back-pressure; keys in SEND are ignored
    rr_hold = 1'b0;
    press_key(4'h2);
    press_enter();
    checkOutput("op2_to_dst", entry_state, S_DST);
    press_key(4'h4);
    press_key(4'h5);
    press_key(4'h6);
    press_enter();
    press_key(4'h0);
    press_key(4'h1);
    press_key(4'h2);
    press_enter();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", req_valid, 1);
      checkOutput("hold_dst", Destination_Account, 12'h456);
      checkOutput("hold_amt", Amount, 12'h012);
      applyStimulus(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    rr_hold = 1'b1;
    idle_cycles(1);
    checkOutput("xfer_done_state", entry_state, S_OPSEL);
    checkOutput("xfer_done_dst", Destination_Account, 0);

    // Exit op returns to idle with everything cleared
    press_key(4'h4);
    press_enter();
    checkOutput("exit_valid", req_valid, 1);
    checkOutput("exit_op", Operation, 4);
    idle_cycles(1);
    check_all_zero("exit_done");

    // Short enter ignored, fourth digit dropped
    press_key(4'hA);
    press_key(4'hB);
    press_enter();
    checkOutput("short_enter_state", entry_state, S_ACC);
    press_key(4'h7);
    press_key(4'h2);
    press_key(4'h9);
    press_key(4'h9);
    checkOutput("acc_saturate", Account_Number, 12'hAB7);

    // Clear mid-PIN, then cancel beats enter
    press_enter();
    press_key(4'h1);
    press_key(4'h2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pin_clear_val", PIN, 0);
    checkOutput("pin_clear_state", entry_state, S_PINE);
    press_key(4'h3);
    press_key(4'h4);
    press_key(4'h5);
    checkOutput("pin_val", PIN, 12'h345);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_all_zero("cancel_enter");

    // Inactivity abort
    press_key(4'h5);
    idle_cycles(7);
    checkOutput("to_not_yet", timeout, 0);
    checkOutput("to_not_yet_state", entry_state, S_ACC);
    idle_cycles(1);
    checkOutput("to_pulse", timeout, 1);
    check_all_zero("to_fields");
    idle_cycles(1);
    checkOutput("to_one_cycle", timeout, 0);

    // Priority: clear beats enter+digit, enter beats digit
    repeat (3) press_key(4'h1);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_prio_state", entry_state, S_ACC);
    checkOutput("clr_prio_acc", Account_Number, 0);
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ent_prio_state", entry_state, S_PINE);
    checkOutput("ent_prio_pin", PIN, 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while a request is offered
    rr_hold = 1'b0;
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_enter();
    press_key(4'h4);
    press_key(4'h5);
    press_key(4'h6);
    press_enter();
    press_key(4'h3);
    press_enter();
    checkOutput("pre_rst_valid", req_valid, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", req_valid, 0);
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Randomised sessions
    rr_hold = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        idle_cycles($urandom_range(6, 10));
      end else begin
        applyStimulus($urandom_range(0, 99) < 55, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 50);
      end
      if (i % 100 == 99) check_model("rand");
    end

    rr_hold = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    #1;
    checkOutput("sb_drained", exp_q.size(), 0);
    checkOutput("timeouts_seen", to_pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
